// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-seg scanner with PWM, LZ suppression, shadow load; SEG7_BLINK_EN adds per-digit blink
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
`ifdef SEG7_BLINK_EN
  parameter int BLINK_DIV  = 50000000,
`endif
  parameter int BRIGHT_W   = 4
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG,
  output logic                    frame_done
);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int SUB = SCAN_DIV >> BRIGHT_W;
  localparam int BW  = $clog2(SUB);
  localparam int DW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_BLINK_EN
  localparam int PW  = 7*NUM_DIGITS + 1;
`else
  localparam int PW  = 6*NUM_DIGITS + 1;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [SW-1:0]         slot_q, slot_d;
  logic [BW-1:0]         sub_q, sub_d;
  logic [BRIGHT_W-1:0]   phase_q, phase_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [PW-1:0]         pend_q, pend_d, act_q, act_d, in_w;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, dp_a, blank_a;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_q, slot_end, boundary, en, sup, dark;
  logic [NUM_DIGITS:0]   zf;
  logic [3:0]            nib;
  // shadow word layout, LSB first: number, dp_mask, blank_mask, lz_suppress[, blink_mask]
`ifdef SEG7_BLINK_EN
  logic [$clog2(BLINK_DIV)-1:0] blink_cnt_q;
  logic                         blink_q, blink_wrap;
  assign in_w       = {blink_mask, lz_suppress, blank_mask, dp_mask, number};
  assign blink_wrap = blink_cnt_q == $clog2(BLINK_DIV)'(BLINK_DIV-1);
  assign dark       = blank_a[digit_q] | (blink_q & act_q[6*NUM_DIGITS+1+digit_q]);
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_q     <= blink_q ^ blink_wrap;
    end
`else
  assign in_w = {lz_suppress, blank_mask, dp_mask, number};
  assign dark = blank_a[digit_q];
`endif
  assign dp_a    = act_q[5*NUM_DIGITS-1:4*NUM_DIGITS];
  assign blank_a = act_q[6*NUM_DIGITS-1:5*NUM_DIGITS];
  always_comb begin
    slot_end     = slot_q == SW'(SCAN_DIV-1);
    boundary     = slot_end && digit_q == DW'(NUM_DIGITS-1);
    slot_d       = slot_end ? '0 : slot_q + 1'b1;
    sub_d        = (slot_end || sub_q == BW'(SUB-1)) ? '0 : sub_q + 1'b1;
    phase_d      = slot_end ? '0 : phase_q + BRIGHT_W'(sub_q == BW'(SUB-1));
    digit_d      = !slot_end ? digit_q : boundary ? '0 : digit_q + 1'b1;
    pend_d       = load ? in_w : pend_q;
    pend_valid_d = load || (pend_valid_q && !boundary);
    act_d        = (boundary && pend_valid_q) ? pend_q : act_q;
  end
  // zf[k]: every nibble from k upward is zero
  always_comb begin
    zf = '0;
    zf[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS-1; k >= 0; k--) zf[k] = zf[k+1] & ~|act_q[4*k +: 4];
    nib   = act_q[{digit_q, 2'b00} +: 4];
    sup   = act_q[6*NUM_DIGITS] && digit_q != '0 && zf[digit_q];
    en    = (phase_q < brightness || &brightness) && slot_q != '0 && !dark;
    an_d  = en ? ~(NUM_DIGITS'(1) << digit_q) : '1;
    seg_d = en ? {~dp_a[digit_q], sup ? 7'h7F : ~GLYPH[nib]} : 8'hFF;
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      slot_q       <= '0;
      sub_q        <= '0;
      phase_q      <= '0;
      digit_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      act_q        <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      frame_q      <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      sub_q        <= sub_d;
      phase_q      <= phase_d;
      digit_q      <= digit_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_q      <= boundary;
    end
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign frame_done = frame_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan timing, PWM, LZ suppression, shadow loading and reset
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] number;
  logic [3:0]  dp, blank, an;
  logic        lz, load, fd;
  logic [1:0]  bright;
  logic [7:0]  seg;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(32), .BRIGHT_W(2)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .number(number), .dp_mask(dp), .blank_mask(blank),
    .lz_suppress(lz), .brightness(bright), .load(load),
`ifdef SEG7_BLINK_EN
    .blink_mask(4'b0000),
`endif
    .AN(an), .SEG(seg), .frame_done(fd));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  // cyc counts rising edges since reset release; we always stand on a falling edge
  task automatic adv_to(input int e);
    while (cyc < e) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    rst_n = 1'b0; number = '0; dp = '0; blank = '0; lz = 1'b0; bright = 2'd3; load = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF); chk("rst_seg", seg, 8'hFF); chk("rst_fd", fd, 1'b0);
    rst_n = 1'b1; cyc = 0;
    number = 16'h1234; load = 1'b1;
    adv_to(1); load = 1'b0;
    chk("guard_first", an, 4'hF);
    adv_to(2);   chk("f0_d0_an", an, 4'hE); chk("f0_d0_seg", seg, 8'hC0);
    adv_to(127); chk("fd_before", fd, 1'b0);
    adv_to(128); chk("fd_pulse1", fd, 1'b1);
    adv_to(129); chk("fd_after", fd, 1'b0); chk("guard_f1", an, 4'hF);
    adv_to(130); chk("d0_an", an, 4'hE); chk("d0_seg", seg, 8'h99);
    adv_to(170); chk("d1_an", an, 4'hD); chk("d1_seg", seg, 8'hB0);
    adv_to(203); chk("d2_an", an, 4'hB); chk("d2_seg", seg, 8'hA4);
    adv_to(225); chk("guard_d3", an, 4'hF);
    adv_to(229); chk("d3_an", an, 4'h7); chk("d3_seg", seg, 8'hF9);
    adv_to(256); chk("fd_pulse2", fd, 1'b1);
    bright = 2'd1;
    adv_to(258); chk("b1_slot1", an, 4'hE);
    adv_to(264); chk("b1_slot7", an, 4'hE);
    adv_to(265); chk("b1_slot8", an, 4'hF);
    bright = 2'd0;
    adv_to(292); chk("b0_off", an, 4'hF);
    bright = 2'd2;
    adv_to(336); chk("b2_slot15", an, 4'hB);
    adv_to(337); chk("b2_slot16", an, 4'hF);
    bright = 2'd3;
    number = 16'h0050; lz = 1'b1; dp = 4'b0001; load = 1'b1;
    adv_to(341); load = 1'b0;
    adv_to(390); chk("lz_d0_an", an, 4'hE); chk("lz_d0_seg", seg, 8'h40);
    adv_to(422); chk("lz_d1_an", an, 4'hD); chk("lz_d1_seg", seg, 8'h92);
    adv_to(454); chk("lz_d2_an", an, 4'hB); chk("lz_d2_seg", seg, 8'hFF);
    adv_to(486); chk("lz_d3_an", an, 4'h7); chk("lz_d3_seg", seg, 8'hFF);
    adv_to(548); number = 16'h1111; lz = 1'b0; dp = 4'b0000; load = 1'b1;
    adv_to(549); load = 1'b0;
    adv_to(582); chk("mid_d2_old_an", an, 4'hB); chk("mid_d2_old_seg", seg, 8'hFF);
    adv_to(614); chk("mid_d3_old_seg", seg, 8'hFF);
    adv_to(646); chk("mid_d0_new_an", an, 4'hE); chk("mid_d0_new_seg", seg, 8'hF9);
    adv_to(742); chk("mid_d3_new_seg", seg, 8'hF9);
    adv_to(767); number = 16'h2222; blank = 4'b1000; load = 1'b1;
    adv_to(768); load = 1'b0; chk("fd_boundary", fd, 1'b1);
    adv_to(774); chk("bnd_still_old", seg, 8'hF9);
    adv_to(896); chk("fd_pulse7", fd, 1'b1);
    adv_to(902); chk("bnd_new_an", an, 4'hE); chk("bnd_new_seg", seg, 8'hA4);
    adv_to(966); chk("d2_lit_an", an, 4'hB); chk("d2_lit_seg", seg, 8'hA4);
    adv_to(998); chk("blank_an", an, 4'hF); chk("blank_seg", seg, 8'hFF);
    adv_to(1090); number = 16'h3333; load = 1'b1;
    adv_to(1091); load = 1'b0;
    adv_to(1095); chk("pre_rst_an", an, 4'hB);
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF); chk("async_seg", seg, 8'hFF); chk("async_fd", fd, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    adv_to(1);   chk("rr_guard", an, 4'hF);
    adv_to(2);   chk("rr_d0_an", an, 4'hE); chk("rr_d0_seg", seg, 8'hC0);
    adv_to(33);  chk("rr_guard_d1", an, 4'hF);
    adv_to(34);  chk("rr_d1_an", an, 4'hD); chk("rr_d1_seg", seg, 8'hC0);
    adv_to(134); chk("rr_pend_lost", seg, 8'hC0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment driver for the Nexys A7-100T 8-digit common-anode display.
- Successor to the fixed 8-digit hex scanner. Adds:
  - configurable digit count and slot length
  - PWM brightness
  - per-digit decimal point and blanking
  - leading-zero suppression
  - tear-free shadow loading
  - inter-digit ghosting guard
- Sits between application logic and the AN/SEG pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned, 1..8.
- SCAN_DIV, 100000: CLK100MHZ cycles per digit slot. Must be a multiple of 2**BRIGHT_W and at least 2*2**BRIGHT_W.
- BRIGHT_W, 4: brightness control width.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous active-low reset.
- number  in  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit.
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of that digit.
- blank_mask  in  NUM_DIGITS  1 = force that digit dark, DP included.
- lz_suppress  in  1  1 = blank leading zero digits.
- brightness  in  BRIGHT_W  0 = off; all-ones = full on.
- load  in  1  capture number/dp_mask/blank_mask/lz_suppress into the pending register.
- AN  out  NUM_DIGITS  digit enables, active low.
- SEG  out  8  {DP,CG,CF,CE,CD,CC,CB,CA}, active low.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset, asynchronous on CPU_RESETN low:
  - AN and SEG all ones.
  - frame_done 0.
  - All counters 0.
  - Pending and active registers 0; pending_valid 0.
- Counters:
  - slot_cnt counts 0..SCAN_DIV-1.
  - At the wrap, digit_idx advances 0..NUM_DIGITS-1 and then wraps to 0.
  - phase = slot_cnt / (SCAN_DIV >> BRIGHT_W), range 0..2**BRIGHT_W-1. Implemented as a sub-counter plus phase counter, no divider.
- Load and shadowing:
  - load=1 copies the inputs into the pending register and sets pending_valid. The last load before the frame boundary wins.
  - Frame boundary: digit_idx=NUM_DIGITS-1 and slot_cnt=SCAN_DIV-1. At that cycle, pending is copied to active if pending_valid, and pending_valid clears.
  - load in the same cycle as the boundary: the new values go to pending and are applied at the next boundary.
  - Display never mixes two loads within one frame.
- Leading-zero suppression:
  - Digit k is suppressed when lz_suppress=1, k>0, and every active nibble from k up to NUM_DIGITS-1 is 0.
  - A suppressed digit shows no segments. Its DP still follows dp_mask unless blank_mask is set.
- Digit enable:
  - enable = (phase < brightness) or (brightness all ones), and slot_cnt != 0, and not blank_mask[digit_idx].
  - The slot_cnt=0 cycle is the ghosting guard: AN all ones.
- Outputs, registered, one-cycle latency from the counter state:
  - AN = enable ? ~(1<<digit_idx) : all ones.
  - SEG = enable ? {~dp, ~seg7(nibble)} : all ones.
- Segment codes use standard hex glyphs 0-9, A, b, C, d, E, F, identical to the existing driver.
- frame_done is registered and high for exactly the cycle after the frame boundary.
- Reset mid-frame: outputs go dark immediately, pending data is lost, and scanning restarts at digit 0.
- NUM_DIGITS=1: every slot end is a frame boundary.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- Defined:
  - Adds input blink_mask[NUM_DIGITS], shadowed with load like the other display inputs.
  - Adds parameter BLINK_DIV, default 50000000.
  - A blink_phase flop toggles every BLINK_DIV cycles and resets to 0.
  - When blink_phase=1, digits whose active blink_mask bit is set are dark, as if blanked.
- Undefined: no port, counter or flop exists, and behaviour is exactly as above.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=32, BRIGHT_W=2 unless stated.
- Reset release, number=0x1234, load once, brightness=3:
  - Digit 0 slots: AN=1110, SEG=0x99.
  - Digit 3 slots: AN=0111, SEG=0xF9.
  - AN=1111 at every slot_cnt=0.
  - frame_done pulses every 128 cycles.
- brightness=1: AN active only for slot_cnt 1..7 of each 32-cycle slot. brightness=0: AN stays 1111.
- number=0x0050, lz_suppress=1, dp_mask=0001:
  - Digits 3 and 2 have AN low with SEG=0xFF.
  - Digit 1 shows SEG=0x92.
  - Digit 0 shows SEG=0x40.
- load 0x1111 mid-frame at digit 1: the remaining digits still show the old value, and the new value appears from digit 0 of the next frame. Load exactly on the boundary cycle: the value is applied one frame later.
- CPU_RESETN pulsed low during digit 2: AN/SEG go to all ones asynchronously, and after release scanning restarts at digit 0 with the active value 0.
- With SEG7_BLINK_EN, BLINK_DIV=256, blink_mask=0010: digit 1 is dark for alternating 256-cycle windows while the other digits are unaffected.
